mul5_share_sched: RTL and testbench
===================================

# mul5_share_sched

Round-robin scheduler that shares a single 5-bit shift-and-add multiply engine among NREQ requesters. Each requester offers an unsigned 5-bit operand pair over a valid/ready handshake. The scheduler grants one requester, runs the 5-cycle partial-product accumulation (one bit of b per cycle, LSB first), and returns the 10-bit product tagged with the requester index over a valid/ready output. It sits between the DSP front-end request ports and the multiplier datapath, and it owns all sequencing of that datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of requester index
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero
- req_a  in  5*NREQ  operand a, requester i at bits [5i+4:5i]
- req_b  in  5*NREQ  operand b, same packing
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  10  unsigned product a*b
- out_id  out  IDW  index of requester that produced out_p
- busy  out  1  high in RUN or DONE

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE:**
  - If any req_valid is set, the arbiter picks one index g and drives req_ready[g]=1 combinationally in the same cycle.
  - At the clock edge, the block captures a_r=req_a[g], b_r=req_b[g], id_r=g, clears acc=0 and cnt=0, and moves to RUN.
  - If no req_valid is set, req_ready=0 and the block stays in IDLE.
- **RUN:**
  - Every cycle: acc <= acc + (b_r[cnt] ? {a_r,cnt zeros} : 0), using a 10-bit add with no overflow possible (max 31*31=961).
  - cnt increments each cycle.
  - On the cycle with cnt==4, the last add is done and the FSM moves to DONE.
  - req_ready=0 throughout RUN.
- **DONE:**
  - out_valid=1, out_p=acc, out_id=id_r, all held stable.
  - When out_valid&out_ready, the FSM moves to IDLE at that edge.
  - With out_ready low, the block stalls indefinitely and no new grant is made.
- **Arbitration (default):**
  - Round-robin. Pointer last holds the most recently granted index and updates only on a grant.
  - The search starts at last+1 and wraps modulo NREQ.
  - last resets to NREQ-1, so requester 0 wins first after reset.
- **Stable request:** a requester deasserting req_valid before being granted is legal. Its operands are only sampled on the grant edge.
- **Operand sampling:** req_a/req_b are ignored outside the grant cycle. A change after grant does not affect the running product.
- **Reset:**
  - Asserting reset in any state returns the block to IDLE, with acc=0, cnt=0, last=NREQ-1 and id_r=0.
  - Any in-flight product is discarded and never presented.
- **Reset values:** req_ready=0, out_valid=0, out_p=0, out_id=0, busy=0.

## Timing
- Grant edge E0. RUN occupies edges E1..E5. out_valid rises in the cycle after E5.
- Latency from grant edge to out_valid is 6 cycles.
- Minimum issue interval is 7 cycles (1 IDLE + 5 RUN + 1 DONE with out_ready=1).
- out_p/out_id change only on the transition into DONE. They hold their value in IDLE/RUN and are not cleared there.
- req_ready is a combinational function of state, req_valid and last. It has no path from out_ready.
- A simultaneous out_ready handshake and new req_valid in DONE produce no grant that cycle. The grant occurs in the following IDLE cycle.

## Configuration
- MUL5_SCHED_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest asserted index wins. last is unused.
  - Undefined: round-robin as above. This is the default build.

## Test plan
- **Reset then single request:** req_valid=4'b0001, a=31, b=31. Expect req_ready=0001 for one cycle, then out_valid 6 cycles later with out_p=961, out_id=0, busy=1 from E0+1 through the handshake.
- **Zero/identity:** a=0,b=27 gives 0; a=19,b=1 gives 19; a=13,b=16 gives 208 (only the cnt=4 add contributes).
- **Round-robin fairness:**
  - All four requesters hold valid continuously, out_ready=1. Grant order is 0,1,2,3,0, with grants every 7 cycles.
  - With MUL5_SCHED_FIXED_PRIO_EN defined, requester 0 is granted every time.
- **Output backpressure:** hold out_ready=0 for 20 cycles in DONE. out_valid, out_p and out_id stay stable and req_ready stays 0. Releasing out_ready gives one handshake, then IDLE.
- **Operand change after grant:** grant requester 2 with a=7,b=9, then change req_a/req_b on the next cycle. Expect out_p=63, out_id=2.
- **Mid-run reset:** assert reset in RUN with cnt==2. Next cycle the block is in IDLE with all outputs 0 and no out_valid for the aborted op. The next grant goes to requester 0.

Source files
------------

// File: rtl/mul5_share_sched.sv
// Round-robin scheduler sharing one 5-cycle shift-and-add 5x5 multiplier among NREQ requesters.
// Define MUL5_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mul5_share_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [5*NREQ-1:0]   req_a,
    input  logic [5*NREQ-1:0]   req_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9:0]          out_p,
    output logic [IDW-1:0]      out_id,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state;
    logic [4:0]     a_r;
    logic [4:0]     b_r;
    logic [IDW-1:0] id_r;
    logic [9:0]     acc;
    logic [2:0]     cnt;
`ifndef MUL5_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0] last;
`endif

    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [4:0]     a_sel;
    logic [4:0]     b_sel;
    logic [9:0]     pp;
    logic [9:0]     acc_next;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
`ifdef MUL5_SCHED_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(i);
            end
        end
`else
        // Search starts just after the last granted index and wraps.
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_any && req_valid[(int'(last) + k) % NREQ]) begin
                grant_any = 1'b1;
                grant_idx = IDW'((int'(last) + k) % NREQ);
            end
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel = req_a[5*i +: 5];
                b_sel = req_b[5*i +: 5];
                req_ready[i] = (state == StIdle) && grant_any;
            end
        end
    end

    always_comb begin
        pp       = b_r[cnt] ? ({5'd0, a_r} << cnt) : 10'd0;
        acc_next = acc + pp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            a_r       <= '0;
            b_r       <= '0;
            id_r      <= '0;
            acc       <= '0;
            cnt       <= '0;
`ifndef MUL5_SCHED_FIXED_PRIO_EN
            last      <= IDW'(NREQ - 1);
`endif
            out_valid <= 1'b0;
            out_p     <= '0;
            out_id    <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant_any) begin
                        a_r   <= a_sel;
                        b_r   <= b_sel;
                        id_r  <= grant_idx;
                        acc   <= '0;
                        cnt   <= '0;
`ifndef MUL5_SCHED_FIXED_PRIO_EN
                        last  <= grant_idx;
`endif
                        busy  <= 1'b1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    acc <= acc_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd4) begin
                        out_valid <= 1'b1;
                        out_p     <= acc_next;
                        out_id    <= id_r;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul5_share_sched.sv
// Bench for mul5_share_sched: per-cycle compare against a transaction-level model plus
// directed literal checks. Honours MUL5_SCHED_FIXED_PRIO_EN when defined.
module tb_mul5_share_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [5*NREQ-1:0] req_a = '0;
    logic [5*NREQ-1:0] req_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [9:0]        out_p;
    logic [IDW-1:0]    out_id;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mul5_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_id    (out_id),
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_ph = cycles since grant (0 idle, 1..5 multiplying, 6 holding result).
    int m_ph = 0;
    int m_last = NREQ - 1;
    int m_prod = 0;
    int m_id = 0;
    int m_outp = 0;
    int m_outid = 0;

    function automatic int m_pick();
        if (m_ph != 0) return -1;
`ifdef MUL5_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (req_valid[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ph    <= 0;
            m_last  <= NREQ - 1;
            m_outp  <= 0;
            m_outid <= 0;
        end else if (m_ph == 0) begin
            if (m_pick() >= 0) begin
                m_ph   <= 1;
                m_last <= m_pick();
                m_id   <= m_pick();
                m_prod <= int'(req_a[5*m_pick() +: 5]) * int'(req_b[5*m_pick() +: 5]);
            end
        end else if (m_ph < 6) begin
            m_ph <= m_ph + 1;
            if (m_ph == 5) begin
                m_outp  <= m_prod;
                m_outid <= m_id;
            end
        end else if (out_ready) begin
            m_ph <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("req_ready", int'(req_ready), (m_pick() >= 0) ? (1 << m_pick()) : 0);
            check("out_valid", int'(out_valid), int'(m_ph == 6));
            check("busy", int'(busy), int'(m_ph != 0));
            check("out_p", int'(out_p), m_outp);
            check("out_id", int'(out_id), m_outid);
        end
    end

    task automatic do_op(input int id, input int a, input int b, input int exp_p);
        int n;
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[5*id +: 5] = 5'(a);
        req_b[5*id +: 5] = 5'(b);
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == '0 && n < 20);
        check("grant", int'(req_ready), 1 << id);
        @(posedge clk); #1;
        req_valid = '0;
        req_a = ~req_a;
        req_b = ~req_b;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        check("latency", n, 6);
        check("product", int'(out_p), exp_p);
        check("product_id", int'(out_id), id);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 30);
        check("drain_timeout", int'(busy), 0);
    endtask

    int gi[$];
    int gc[$];
    int exp_order[5];
    int n;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_p", int'(out_p), 0);
        check("rst_out_id", int'(out_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 0);

        do_op(0, 31, 31, 961);
        do_op(1, 0, 27, 0);
        do_op(3, 19, 1, 19);
        do_op(2, 13, 16, 208);
        do_op(2, 7, 9, 63);

        // Fairness: all requesters valid continuously from a fresh reset.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        req_valid = '1;
        req_a = {5'd3, 5'd5, 5'd7, 5'd11};
        req_b = {5'd2, 5'd4, 5'd6, 5'd8};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && gi.size() < 5) begin
                    gi.push_back(i);
                    gc.push_back(c);
                end
            end
        end
        @(posedge clk); #1 req_valid = '0;
`ifdef MUL5_SCHED_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        check("grant_count", gi.size(), 5);
        if (gi.size() == 5) begin
            for (int k = 0; k < 5; k++) check("grant_order", gi[k], exp_order[k]);
            for (int k = 1; k < 5; k++) check("grant_interval", gc[k] - gc[k-1], 7);
        end
        drain();

        // Backpressure: hold the result for 20 cycles while others request.
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_a = {5'd1, 5'd2, 5'd25, 5'd4};
        req_b = {5'd1, 5'd2, 5'd6, 5'd4};
        req_valid = 4'b0010;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == '0 && n < 20);
        check("bp_grant", int'(req_ready), 2);
        @(posedge clk); #1 req_valid = '1;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        check("bp_latency", n, 6);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_p", int'(out_p), 150);
            check("bp_id", int'(out_id), 1);
            check("bp_ready", int'(req_ready), 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_released", int'(out_valid), 0);
`ifdef MUL5_SCHED_FIXED_PRIO_EN
        check("bp_next_grant", int'(req_ready), 1);
`else
        check("bp_next_grant", int'(req_ready), 4);
`endif

        // Mid-run reset with cnt==2: grant edge, then two more edges.
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mr_out_valid", int'(out_valid), 0);
        check("mr_out_p", int'(out_p), 0);
        check("mr_out_id", int'(out_id), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_grant", int'(req_ready), 1);
        @(posedge clk); #1 req_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        check("mr_latency", n, 6);
        check("mr_product", int'(out_p), 16);
        check("mr_id", int'(out_id), 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
